// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned ERR_W      = 3;

  localparam logic [ERR_W-1:0] ERR_BOTH  = 3'b001;
  localparam logic [ERR_W-1:0] ERR_ALIGN = 3'b010;
  localparam logic [ERR_W-1:0] ERR_RANGE = 3'b100;

  // Latched request payload carried from IDLE through BUSY/DONE
  typedef struct packed {
    logic                  is_wr;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] wdata;
  } req_lat_t;

  // One bit per reason a request is rejected; zero means legal
  function automatic logic [ERR_W-1:0] illegal_reasons(input logic ren, input logic wen,
                                                       input logic [DATA_WIDTH-1:0] addr,
                                                       input int unsigned addr_width);
    logic [ERR_W-1:0] r;
    r = '0;
    if (ren && wen) r |= ERR_BOTH;
    if ((addr & DATA_WIDTH'(WORD_BYTES - 1)) != '0) r |= ERR_ALIGN;
    if ((addr >> (addr_width + $clog2(WORD_BYTES))) != '0) r |= ERR_RANGE;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data memory bus between the core (master) and the responder (slave).
interface data_mem_responder_if;
  logic                                   mem_ren;
  logic                                   mem_wen;
  logic [data_mem_resp_pkg::DATA_WIDTH-1:0] mem_addr;
  logic [data_mem_resp_pkg::DATA_WIDTH-1:0] mem_dout;
  logic [data_mem_resp_pkg::DATA_WIDTH-1:0] mem_din;
  logic                                   mem_stall;
  logic                                   mem_err;

  modport master (output mem_ren, mem_wen, mem_addr, mem_dout,
                  input  mem_din, mem_stall, mem_err);
  modport slave  (input  mem_ren, mem_wen, mem_addr, mem_dout,
                  output mem_din, mem_stall, mem_err);
endinterface

// File: rtl/data_mem_responder_sram.sv
// Single-port synchronous word RAM; read data registered and held while idle or writing.
module data_mem_sram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: wait-state FSM, legality check and access counters.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);
  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  req_lat_t                lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    din_zero_q, din_zero_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic                    req_c;
  logic                    ram_en_c, ram_we_c;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  assign req_c = bus.mem_ren | bus.mem_wen;

  // Next-state, request latch, array strobe and counter updates
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    idx_d      = idx_q;
    err_d      = 1'b0;
    din_zero_d = din_zero_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    ram_en_c   = 1'b0;
    ram_we_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          lat_d.is_wr   = bus.mem_wen;
          lat_d.illegal = |illegal_reasons(bus.mem_ren, bus.mem_wen, bus.mem_addr, ADDR_WIDTH);
          lat_d.wdata   = bus.mem_dout;
          idx_d         = bus.mem_addr[ADDR_WIDTH+1:2];
          cnt_d         = WAIT_W'(WAIT_CYCLES);
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          state_d = DONE;
          err_d   = lat_q.illegal;
          if (lat_q.illegal) begin
            din_zero_d = 1'b1;
          end else begin
            ram_en_c = 1'b1;
            ram_we_c = lat_q.is_wr;
            if (!lat_q.is_wr) din_zero_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!lat_q.illegal) begin
          if (lat_q.is_wr && (wr_cnt_q != '1))  wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
          if (!lat_q.is_wr && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      din_zero_q <= 1'b1;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      din_zero_q <= din_zero_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  data_mem_sram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .addr  (idx_q),
    .wdata (lat_q.wdata),
    .rdata (ram_rdata)
  );

  // Stall is combinational from req so the core freezes in the request cycle itself
  assign bus.mem_stall = rst_n & (((state_q == IDLE) & req_c) | (state_q == BUSY));
  assign bus.mem_din   = din_zero_q ? '0 : ram_rdata;
  assign bus.mem_err   = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the pipeline's MEM-stage data memory interface. The core acts as initiator through mem_ren, mem_wen, mem_addr, mem_dout and mem_din.
- Holds a word-addressed synchronous SRAM. Inserts a programmable number of wait states and drives mem_stall to the pipeline controller, which freezes the stages while stall is high.
- Reports misaligned and out-of-range accesses.
- Keeps saturating read/write access counters for the debug mux.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, extra BUSY cycles before the array access (0..15).
- CNT_WIDTH, 16, width of the debug access counters.

Ports:
- clk  input  1  main clock
- rst_n  input  1  asynchronous active-low reset
- mem_ren  input  1  read request from MEM stage
- mem_wen  input  1  write request from MEM stage
- mem_addr  input  32  byte address
- mem_dout  input  32  write data from core
- mem_din  output  32  read data to core
- mem_stall  output  1  high while the request is not yet complete
- mem_err  output  1  one-cycle pulse in DONE for an illegal request
- rd_count  output  CNT_WIDTH  completed legal reads, saturating
- wr_count  output  CNT_WIDTH  completed legal writes, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low forces state=IDLE, cnt=0, mem_din=0, mem_err=0, rd_count=0, wr_count=0. mem_stall=0 while rst_n is low. SRAM contents are not reset.
- Request: req = mem_ren | mem_wen. The core holds addr and data stable while mem_stall is high.
- Legality: illegal = (mem_ren & mem_wen) | (mem_addr[1:0] != 0) | (mem_addr[31:ADDR_WIDTH+2] != 0).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req, latch op, word index mem_addr[ADDR_WIDTH+1:2], wdata and illegal; load cnt=WAIT_CYCLES; go BUSY. Otherwise stay in IDLE.
  - BUSY: if cnt != 0, decrement cnt. If cnt == 0, then on that edge:
    - legal read: mem_din <= array[idx]
    - legal write: array[idx] <= wdata
    - illegal: no array access; mem_din <= 0
    - go DONE.
  - DONE: mem_err = latched illegal. Increment the matching counter if legal; counters saturate at all-ones. Go IDLE unconditionally.
- mem_stall = (state==IDLE & req) | (state==BUSY). It is combinational from req in IDLE so the core freezes in the first cycle. It is 0 in DONE.
- Latency: a request first seen in IDLE at cycle t stalls for WAIT_CYCLES+2 cycles. Data is valid and stall is low at cycle t+WAIT_CYCLES+2.
- mem_din holds its last value until the next read completes. Writes and illegal reads set it to 0 only as stated above.
- Back-to-back accesses: DONE always returns to IDLE, so consecutive requests are separated by exactly one DONE cycle.
- If a request is still asserted in IDLE after DONE (the core is held for another reason), it is re-executed. Reads and writes are idempotent; counters count it again.
- Input changes during BUSY are ignored because the request is latched.
- rst_n asserted mid-BUSY aborts the access: no array write, no counter update, state returns to IDLE.

Decomposition:
- Package data_mem_resp_pkg:
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - WORD_BYTES=4
  - illegal-reason constants ERR_BOTH, ERR_ALIGN, ERR_RANGE, for bench and debug decode
- One sub-module, data_mem_sram: single-port synchronous RAM, depth 2**ADDR_WIDTH × 32, with inputs clk, en, we, addr, wdata and output rdata registered. No reset.
- The FSM, legality check and counters live in the top module.

Test Plan:
- WAIT_CYCLES=2. Write 0xDEADBEEF to 0x0000_0010, then read 0x10 → stall high for 4 cycles per request; mem_din=0xDEADBEEF in the read's DONE cycle; wr_count=1, rd_count=1.
- WAIT_CYCLES=0. Read an address never written after a known preload of 0x12345678 → stall 2 cycles; DONE data matches; mem_err=0.
- Read 0x0000_0006 (misaligned) and 0x0000_1000 (out of range for ADDR_WIDTH=10) → each stalls 4 cycles; mem_err pulses 1 cycle; mem_din=0; counters unchanged.
- mem_ren=mem_wen=1 to 0x20 with data 0xAAAA5555 → mem_err pulse; a subsequent read of 0x20 returns the prior contents.
- Assert rst_n low during BUSY of a write of 0x11111111 to 0x40, then release and read 0x40 → old value returned; wr_count=0; mem_stall was 0 during reset.
- Issue 0xFFFF+5 legal reads with CNT_WIDTH=16 → rd_count saturates at 0xFFFF.
